// File: rtl/riscv_ctrl_pkg.sv
// Shared control encodings for the RV32I multi-cycle core: opcodes, FSM states,
// ALU/PC/writeback select codes and the opcode-to-class map.
package riscv_ctrl_pkg;

    localparam logic [6:0] OPC_LUI      = 7'h37;
    localparam logic [6:0] OPC_AUIPC    = 7'h17;
    localparam logic [6:0] OPC_JAL      = 7'h6F;
    localparam logic [6:0] OPC_JALR     = 7'h67;
    localparam logic [6:0] OPC_BRANCH   = 7'h63;
    localparam logic [6:0] OPC_LOAD     = 7'h03;
    localparam logic [6:0] OPC_STORE    = 7'h23;
    localparam logic [6:0] OPC_OP_IMM   = 7'h13;
    localparam logic [6:0] OPC_OP       = 7'h33;
    localparam logic [6:0] OPC_MISC_MEM = 7'h0F;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_e;

    typedef enum logic [1:0] {
        PC_PLUS4 = 2'd0,
        PC_IMM   = 2'd1,
        PC_ALU   = 2'd2
    } pc_src_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_e;

    typedef enum logic [3:0] {
        CLS_LUI,
        CLS_AUIPC,
        CLS_JAL,
        CLS_JALR,
        CLS_BRANCH,
        CLS_LOAD,
        CLS_STORE,
        CLS_OP_IMM,
        CLS_OP,
        CLS_MISC_MEM,
        CLS_ILLEGAL
    } op_class_e;

    // SYSTEM (ECALL/EBREAK) deliberately lands in CLS_ILLEGAL: both halt the core.
    function automatic op_class_e classify(input logic [6:0] opc);
        classify = CLS_ILLEGAL;
        case (opc)
            OPC_LUI:      classify = CLS_LUI;
            OPC_AUIPC:    classify = CLS_AUIPC;
            OPC_JAL:      classify = CLS_JAL;
            OPC_JALR:     classify = CLS_JALR;
            OPC_BRANCH:   classify = CLS_BRANCH;
            OPC_LOAD:     classify = CLS_LOAD;
            OPC_STORE:    classify = CLS_STORE;
            OPC_OP_IMM:   classify = CLS_OP_IMM;
            OPC_OP:       classify = CLS_OP;
            OPC_MISC_MEM: classify = CLS_MISC_MEM;
            default:      classify = CLS_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational map from instruction class, funct3 and instruction bit 30 to the ALU op.
// Zero latency; no handshake.
module alu_op_decode
    import riscv_ctrl_pkg::*;
(
    input  op_class_e  op_class_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7_5_i,
    output alu_op_e    alu_op_o
);

    always_comb begin
        alu_op_o = ALU_ADD;
        case (op_class_i)
            CLS_OP, CLS_OP_IMM: begin
                case (funct3_i)
                    // Bit 30 means SUB only for register-register ops; ADDI has no SUBI.
                    3'b000: alu_op_o = (op_class_i == CLS_OP && funct7_5_i) ? ALU_SUB : ALU_ADD;
                    3'b001: alu_op_o = ALU_SLL;
                    3'b010: alu_op_o = ALU_SLT;
                    3'b011: alu_op_o = ALU_SLTU;
                    3'b100: alu_op_o = ALU_XOR;
                    3'b101: alu_op_o = funct7_5_i ? ALU_SRA : ALU_SRL;
                    3'b110: alu_op_o = ALU_OR;
                    3'b111: alu_op_o = ALU_AND;
                    default: alu_op_o = ALU_ADD;
                endcase
            end
            CLS_LUI:    alu_op_o = ALU_PASS_B;
            CLS_BRANCH: alu_op_o = ALU_SUB;
            default:    alu_op_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB, branch resolution, retire count.
// Strobes are combinational from state and ready inputs; FETCH and MEM stall on imem_ready/dmem_ready.
module control_sequencer
    import riscv_ctrl_pkg::*;
#(
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic                 funct7_5,
    input  logic [4:0]           rd,
    input  logic                 cmp_eq,
    input  logic                 cmp_lt,
    input  logic                 cmp_ltu,
    input  logic                 imem_ready,
    input  logic                 dmem_ready,
    output logic                 imem_req,
    output logic                 ir_write,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic                 pc_write,
    output logic [1:0]           pc_src,
    output logic                 alu_src_a,
    output logic                 alu_src_b,
    output logic [3:0]           alu_op,
    output logic                 reg_write,
    output logic [1:0]           wb_sel,
    output logic                 branch_taken,
    output logic                 trap,
    output logic [INSTRET_W-1:0] instret
);

    state_e                 state_q, state_d;
    logic                   trap_q;
    logic [INSTRET_W-1:0]   instret_q;
    logic                   retire;
    op_class_e              op_class;
    alu_op_e                dec_alu_op;
    logic                   br_cond;
    logic                   br_illegal;
    logic                   is_jump;

    assign op_class = classify(opcode);
    assign is_jump  = (op_class == CLS_JAL) || (op_class == CLS_JALR);

    alu_op_decode u_alu_op_decode (
        .op_class_i (op_class),
        .funct3_i   (funct3),
        .funct7_5_i (funct7_5),
        .alu_op_o   (dec_alu_op)
    );

    always_comb begin
        br_cond    = 1'b0;
        br_illegal = 1'b0;
        case (funct3)
            3'b000:  br_cond = cmp_eq;
            3'b001:  br_cond = !cmp_eq;
            3'b100:  br_cond = cmp_lt;
            3'b101:  br_cond = !cmp_lt;
            3'b110:  br_cond = cmp_ltu;
            3'b111:  br_cond = !cmp_ltu;
            default: br_illegal = 1'b1;
        endcase
    end

    // Reset gates every output so an abort mid-instruction drops strobes without waiting for a clock.
    always_comb begin
        state_d      = state_q;
        retire       = 1'b0;
        imem_req     = 1'b0;
        ir_write     = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        pc_write     = 1'b0;
        pc_src       = PC_PLUS4;
        alu_src_a    = 1'b0;
        alu_src_b    = 1'b0;
        alu_op       = ALU_ADD;
        reg_write    = 1'b0;
        wb_sel       = WB_ALU;
        branch_taken = 1'b0;
        if (!reset) begin
            case (state_q)
                ST_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        ir_write = 1'b1;
                        state_d  = ST_DECODE;
                    end
                end
                ST_DECODE: state_d = (op_class == CLS_ILLEGAL) ? ST_TRAP : ST_EXEC;
                ST_EXEC: begin
                    alu_op  = dec_alu_op;
                    state_d = ST_WB;
                    case (op_class)
                        CLS_OP_IMM, CLS_LOAD, CLS_STORE, CLS_JALR: alu_src_b = 1'b1;
                        CLS_LUI:   alu_src_b = 1'b1;
                        CLS_AUIPC: begin
                            alu_src_a = 1'b1;
                            alu_src_b = 1'b1;
                        end
                        default: ;
                    endcase
                    case (op_class)
                        CLS_BRANCH: begin
                            if (br_illegal) begin
                                state_d = ST_TRAP;
                            end else begin
                                branch_taken = br_cond;
                                pc_write     = 1'b1;
                                pc_src       = br_cond ? PC_IMM : PC_PLUS4;
                                retire       = 1'b1;
                                state_d      = ST_FETCH;
                            end
                        end
                        CLS_JAL: begin
                            pc_write = 1'b1;
                            pc_src   = PC_IMM;
                        end
                        CLS_JALR: begin
                            pc_write = 1'b1;
                            pc_src   = PC_ALU;
                        end
                        CLS_MISC_MEM: begin
                            pc_write = 1'b1;
                            retire   = 1'b1;
                            state_d  = ST_FETCH;
                        end
                        CLS_LOAD, CLS_STORE: state_d = ST_MEM;
                        default: ;
                    endcase
                end
                ST_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = (op_class == CLS_STORE);
                    if (dmem_ready) begin
                        if (op_class == CLS_STORE) begin
                            pc_write = 1'b1;
                            retire   = 1'b1;
                            state_d  = ST_FETCH;
                        end else begin
                            state_d  = ST_WB;
                        end
                    end
                end
                ST_WB: begin
                    reg_write = (rd != 5'd0);
                    if (op_class == CLS_LOAD) begin
                        wb_sel = WB_MEM;
                    end else if (is_jump) begin
                        wb_sel = WB_PC4;
                    end
                    pc_write = !is_jump;
                    retire   = 1'b1;
                    state_d  = ST_FETCH;
                end
                ST_TRAP: state_d = ST_TRAP;
                default: state_d = ST_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            trap_q    <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_d == ST_TRAP) begin
                trap_q <= 1'b1;
            end
            if (retire) begin
                instret_q <= instret_q + INSTRET_W'(1);
            end
        end
    end

    assign trap    = trap_q;
    assign instret = instret_q;

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Multi-cycle control FSM for the RISC-V RV32I core. It sequences the instruction fetch unit, decoder, register file, ALU and data memory through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK. It also drives every datapath select and write strobe, and resolves branch conditions. It sits beside the datapath in `riscv_processor` and replaces the unconnected control inputs there.

## Interface
- `INSTRET_W`, 32: width of the retired-instruction counter.

- `clk`  in  1  core clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `opcode`  in  7  from decoder (IR held stable from DECODE onward).
- `funct3`  in  3  from decoder.
- `funct7_5`  in  1  bit 30 of the instruction.
- `rd`  in  5  destination register index.
- `cmp_eq`, `cmp_lt`, `cmp_ltu`  in  1 each  rs1/rs2 comparator flags, valid in EXECUTE.
- `imem_ready`  in  1  instruction word valid this cycle.
- `dmem_ready`  in  1  data access complete this cycle.
- `imem_req`  out  1  fetch request.
- `ir_write`  out  1  latch fetched word into IR.
- `dmem_req`  out  1  data memory request.
- `dmem_we`  out  1  store when high, qualified by `dmem_req`.
- `pc_write`  out  1  update PC this cycle.
- `pc_src`  out  2  PC source: 0 = pc+4, 1 = pc+imm, 2 = {alu_result[31:1],0}.
- `alu_src_a`  out  1  ALU operand A: 0 = rs1, 1 = pc.
- `alu_src_b`  out  1  ALU operand B: 0 = rs2, 1 = imm.
- `alu_op`  out  4  ALU operation: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, PASS_B=10.
- `reg_write`  out  1  register file write strobe.
- `wb_sel`  out  2  writeback source: 0 = ALU, 1 = mem, 2 = pc+4.
- `branch_taken`  out  1  branch condition true, valid in EXECUTE.
- `trap`  out  1  sticky halt, set on illegal instruction, ECALL or EBREAK.
- `instret`  out  INSTRET_W  count of retired instructions.

## Operation
- State register encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- **FETCH**
  - `imem_req`=1.
  - Holds until `imem_ready`.
  - On `imem_ready`: `ir_write`=1 for one cycle, then go to DECODE.
- **DECODE**
  - Classifies `opcode`.
  - Any of LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP or MISC-MEM goes to EXEC.
  - SYSTEM or any other opcode goes to TRAP.
- **EXEC**
  - ALU operand and op selects by instruction class:
    - OP: a=rs1, b=rs2. `alu_op` from funct3; funct7_5 selects SUB or SRA.
    - OP-IMM: a=rs1, b=imm. funct7_5 is honoured only for funct3=101 (SRAI).
    - LOAD, STORE, JALR: a=rs1, b=imm, ADD.
    - AUIPC: a=pc, b=imm, ADD.
    - LUI: b=imm, PASS_B.
    - BRANCH: SUB.
  - Branch conditions:
    - BEQ = eq, BNE = !eq.
    - BLT = lt, BGE = !lt.
    - BLTU = ltu, BGEU = !ltu.
    - funct3 010 or 011 goes to TRAP.
  - BRANCH: `pc_write`=1, `pc_src` = taken ? 1 : 0, then go to FETCH; the instruction retires.
  - JAL: `pc_src`=1. JALR: `pc_src`=2. Both set `pc_write`=1 and go to WB.
  - MISC-MEM: treated as a NOP. `pc_write`=1, `pc_src`=0, go to FETCH; the instruction retires.
  - LOAD and STORE go to MEM. All other classes go to WB.
- **MEM**
  - `dmem_req`=1, `dmem_we` = store.
  - Holds until `dmem_ready`.
  - LOAD: go to WB.
  - STORE: `pc_write`=1, `pc_src`=0, go to FETCH; the instruction retires.
- **WB**
  - `reg_write` = (rd != 0).
  - `wb_sel`: 1 for LOAD, 2 for JAL/JALR, 0 otherwise.
  - `pc_write`=1 with `pc_src`=0, except JAL/JALR, whose PC was already written in EXEC.
  - Go to FETCH; the instruction retires.
- **TRAP**
  - `trap`=1.
  - All strobes are 0.
  - Held until reset.
- `instret` increments by 1 on every retire edge and wraps modulo 2^INSTRET_W.
- Strobes (`imem_req`, `ir_write`, `dmem_req`, `dmem_we`, `pc_write`, `reg_write`) are combinational from state and inputs. They are forced to 0 while `reset` is high.

## Timing
- Reset values:
  - State = FETCH.
  - `instret`=0, `trap`=0.
  - All strobes 0.
  - `pc_src`, `alu_src_a`, `alu_src_b`, `alu_op`, `wb_sel` = 0.
  - `branch_taken`=0.
- Reset mid-instruction:
  - Aborts immediately: `dmem_req` and `reg_write` drop asynchronously.
  - No retire is counted.
  - First cycle after reset deassertion is FETCH with `imem_req`=1.
- Cycle counts with zero-wait memory (ready in first request cycle):
  - OP, OP-IMM, LUI, AUIPC, JAL, JALR: 4.
  - LOAD: 5.
  - STORE: 4.
  - BRANCH, MISC-MEM: 3.
- Each wait cycle on `imem_ready`/`dmem_ready` adds one cycle. Request stays asserted and IR/PC are untouched.
- A ready input asserted outside its state is ignored.
- `pc_write` asserts in exactly one cycle per instruction.
- `reg_write` asserts in at most one cycle per instruction.

## Structure
- Shared package `riscv_ctrl_pkg` holds:
  - Opcode constants.
  - State encoding.
  - `alu_op`, `pc_src` and `wb_sel` encodings.
  - Datapath and ALU import the same package.
- One combinational sub-module, `alu_op_decode`: maps (opcode class, funct3, funct7_5) to `alu_op`.
- FSM, branch resolution and `instret` live in `control_sequencer`.

## Test plan
- **ADD x3,x1,x2, zero-wait**:
  - Response: states 0→1→2→4→0.
  - `alu_op`=1 only for funct7_5=1 (SUB). ADD gives `alu_op`=0.
  - `reg_write` and `pc_write`(src 0) in cycle 4.
  - `instret` 0→1.
- **LW with `dmem_ready` delayed 3 cycles**:
  - Response: MEM held 4 cycles with `dmem_req`=1, `dmem_we`=0.
  - WB with `wb_sel`=1.
  - Total 8 cycles.
- **BNE, cmp_eq=0 then BNE, cmp_eq=1**:
  - Response: `branch_taken`=1, `pc_src`=1 for the first.
  - `pc_src`=0 for the second.
  - Each 3 cycles, no `reg_write`.
- **JAL with rd=0**:
  - Response: EXEC `pc_write`, `pc_src`=1.
  - WB `reg_write`=0, `pc_write`=0.
  - `instret` increments.
- **Opcode 0x73 (ECALL) and opcode 0x7F**:
  - Response: TRAP after DECODE, `trap`=1 stays set for 20 cycles.
  - No strobes during TRAP.
  - Reset clears `trap` to 0.
- **Assert `reset` during MEM of SW**:
  - Response: `dmem_req` drops same cycle, `instret` unchanged at 0.
  - After deassertion: FETCH, `imem_req`=1.
